registers_sb: RTL and testbench
===============================

Name: registers_sb

Overview:
- Parametrised successor to the single-cycle CPU register file, for the pipelined datapath.
- Depth, width and read-port count are configurable.
- Adds asynchronous reset, an optional hardwired-zero register, same-cycle write-to-read bypass, and a per-register pending-write scoreboard.
- The scoreboard gives hazard-detection logic per-read-port busy flags and a pending-write count.

Parameters:
- DATA_WIDTH, 32, bits per register.
- ADDR_WIDTH, 5, register address width; depth = 2**ADDR_WIDTH.
- READ_PORTS, 2, number of independent combinational read ports (1..4).
- ZERO_REG, 1, when 1 register 0 always reads 0, ignores writes and is never pending.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- regWrite  input  1  write enable for writeback.
- writeRegister  input  ADDR_WIDTH  writeback destination.
- writeData  input  DATA_WIDTH  writeback data.
- issueValid  input  1  an instruction with a destination issues this cycle.
- issueRegister  input  ADDR_WIDTH  destination of the issuing instruction.
- readRegister  input  READ_PORTS*ADDR_WIDTH  flattened read addresses; port i = bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- readData  output  READ_PORTS*DATA_WIDTH  flattened read data, same slicing by DATA_WIDTH.
- busy  output  READ_PORTS  busy[i]=1 means port i's register awaits a writeback that is not arriving this cycle.
- pendingCount  output  ADDR_WIDTH+1  registered number of pending registers.

Behaviour:
- Reset (reset_n=0, asynchronous, no clock required):
  - all registers cleared to 0;
  - all pending bits cleared;
  - pendingCount=0.
  - readData then reflects 0 combinationally; busy=0.
  - Reset asserted mid-operation discards any in-flight write on that edge.
- Write:
  - On a posedge with reset_n=1 and regWrite=1, registers[writeRegister] <= writeData.
  - The write is suppressed when ZERO_REG=1 and writeRegister=0.
- Read (combinational, zero latency) for port i, addr a = readRegister slice i:
  - if ZERO_REG=1 and a=0 -> 0;
  - else if regWrite=1 and writeRegister=a -> writeData (bypass, write-through);
  - else -> registers[a].
  - All ports are independent; any number may read the same address.
- Scoreboard: pending[0..2**ADDR_WIDTH-1], updated on posedge in priority order:
  1. regWrite=1 clears pending[writeRegister];
  2. issueValid=1 sets pending[issueRegister] (issue wins over a same-register clear in the same cycle: the newer producer is outstanding);
  3. with ZERO_REG=1, pending[0] is forced to 0 and an issue to register 0 is ignored.
  - Writeback to a non-pending register is legal; it writes data and leaves pending at 0.
  - Issue to an already-pending register keeps it at 1 (no counting per register).
- busy[i] = pending[a] AND NOT (regWrite=1 AND writeRegister=a). The bypass satisfies the reader, so busy is 0 in the writeback cycle. busy[i] is 0 for a=0 when ZERO_REG=1.
- pendingCount:
  - registered;
  - equals the population count of the post-update pending vector;
  - range 0..2**ADDR_WIDTH (2**ADDR_WIDTH-1 when ZERO_REG=1);
  - no wrap.
- No other state; no X may reach outputs after reset.

Test Plan:
- Reset: write 0xDEADBEEF to r5, then pulse reset_n low mid-cycle without a clock edge -> readData(r5)=0 immediately, pendingCount=0, busy=0.
- Bypass: regWrite=1, writeRegister=7, writeData=0x12345678, port0 and port1 both read r7 in the same cycle -> both readData=0x12345678 before the edge; after the edge both still read 0x12345678 with regWrite=0.
- Zero register: ZERO_REG=1, write 0xFFFFFFFF to r0, issue r0 -> readData(r0)=0, pendingCount unchanged, busy=0; repeat with ZERO_REG=0 -> r0 reads 0xFFFFFFFF and pendingCount increments.
- Scoreboard: issue r3, next cycle issue r4 -> pendingCount=2, port0 reading r3 shows busy[0]=1. Writeback r3=0xA -> busy[0]=0 in that cycle; pendingCount=1 after the edge.
- Simultaneous: r9 pending, same cycle regWrite r9=0x55 and issueValid r9 -> r9 reads 0x55, pending[r9] stays 1, pendingCount unchanged.
- Multi-port: READ_PORTS=4, DATA_WIDTH=16, ADDR_WIDTH=3; fill r1..r7 with 0x1111*n; read ports 1,3,5,7 -> correct slices; issue all 7 -> pendingCount=7, no overflow.

Source files
------------

// File: rtl/registers_sb.sv
// registers_sb: parametrised register file for the pipelined datapath.
// Combinational read ports with same-cycle write bypass, an optional
// hardwired-zero register, and a pending-write scoreboard that drives
// per-port busy flags and a registered pending-register count.
module registers_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int READ_PORTS = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             regWrite,
    input  logic [ADDR_WIDTH-1:0]            writeRegister,
    input  logic [DATA_WIDTH-1:0]            writeData,
    input  logic                             issueValid,
    input  logic [ADDR_WIDTH-1:0]            issueRegister,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] readRegister,
    output logic [READ_PORTS*DATA_WIDTH-1:0] readData,
    output logic [READ_PORTS-1:0]            busy,
    output logic [ADDR_WIDTH:0]              pendingCount
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]      r_pending;
    logic [ADDR_WIDTH:0]   r_count;

    logic                  w_wr_en;
    logic [DEPTH-1:0]      w_pending_next;
    logic [ADDR_WIDTH:0]   w_count_next;

    // Register 0 ignores writes when it is hardwired to zero.
    assign w_wr_en = regWrite && !((ZERO_REG != 0) && (writeRegister == '0));

    // Register array: cleared asynchronously, written on writeback.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_regs[k] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[writeRegister] <= writeData;
        end
    end

    // Next scoreboard state: writeback clears, then issue sets (newer producer wins).
    always_comb begin
        w_pending_next = r_pending;
        if (regWrite) begin
            w_pending_next[writeRegister] = 1'b0;
        end
        if (issueValid) begin
            w_pending_next[issueRegister] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            w_pending_next[0] = 1'b0;
        end
    end

    // Population count of the post-update pending vector.
    always_comb begin
        w_count_next = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_count_next = w_count_next + {{ADDR_WIDTH{1'b0}}, w_pending_next[k]};
        end
    end

    // Scoreboard and its count are registered together so they always agree.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= '0;
            r_count   <= '0;
        end else begin
            r_pending <= w_pending_next;
            r_count   <= w_count_next;
        end
    end

    assign pendingCount = r_count;

    // Independent read ports: zero register, then bypass, then stored value.
    for (genvar g = 0; g < READ_PORTS; g++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_addr;
        logic                  w_zero;
        logic                  w_byp;

        assign w_addr = readRegister[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_zero = (ZERO_REG != 0) && (w_addr == '0);
        assign w_byp  = regWrite && (writeRegister == w_addr);

        assign readData[g*DATA_WIDTH +: DATA_WIDTH] =
            w_zero ? '0 : (w_byp ? writeData : r_regs[w_addr]);

        // A writeback arriving this cycle satisfies the reader through the bypass.
        assign busy[g] = !w_zero && r_pending[w_addr] && !w_byp;
    end

endmodule

// File: tb/tb_registers_sb.sv
// Directed self-checking bench for registers_sb: three instances cover the
// default configuration, ZERO_REG=0, and a 4-port 16-bit 8-entry variant.
module tb_registers_sb;

    logic clock;
    logic reset_n;

    // Instance A: defaults (32-bit, 32 entries, 2 ports, zero register)
    logic        a_we;
    logic [4:0]  a_wa;
    logic [31:0] a_wd;
    logic        a_iv;
    logic [4:0]  a_ir;
    logic [9:0]  a_ra;
    logic [63:0] a_rd;
    logic [1:0]  a_busy;
    logic [5:0]  a_pc;

    // Instance B: no hardwired zero register
    logic        b_we;
    logic [4:0]  b_wa;
    logic [31:0] b_wd;
    logic        b_iv;
    logic [4:0]  b_ir;
    logic [9:0]  b_ra;
    logic [63:0] b_rd;
    logic [1:0]  b_busy;
    logic [5:0]  b_pc;

    // Instance C: 4 ports, 16-bit data, 8 entries
    logic        c_we;
    logic [2:0]  c_wa;
    logic [15:0] c_wd;
    logic        c_iv;
    logic [2:0]  c_ir;
    logic [11:0] c_ra;
    logic [63:0] c_rd;
    logic [3:0]  c_busy;
    logic [3:0]  c_pc;

    int checks = 0;
    int errors = 0;

    registers_sb u_a (
        .clock(clock), .reset_n(reset_n), .regWrite(a_we), .writeRegister(a_wa),
        .writeData(a_wd), .issueValid(a_iv), .issueRegister(a_ir),
        .readRegister(a_ra), .readData(a_rd), .busy(a_busy), .pendingCount(a_pc)
    );

    registers_sb #(.ZERO_REG(0)) u_b (
        .clock(clock), .reset_n(reset_n), .regWrite(b_we), .writeRegister(b_wa),
        .writeData(b_wd), .issueValid(b_iv), .issueRegister(b_ir),
        .readRegister(b_ra), .readData(b_rd), .busy(b_busy), .pendingCount(b_pc)
    );

    registers_sb #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .READ_PORTS(4), .ZERO_REG(1)) u_c (
        .clock(clock), .reset_n(reset_n), .regWrite(c_we), .writeRegister(c_wa),
        .writeData(c_wd), .issueValid(c_iv), .issueRegister(c_ir),
        .readRegister(c_ra), .readData(c_rd), .busy(c_busy), .pendingCount(c_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic test_reset;
        // Write r5, mark r6 pending, then reset without a clock edge.
        @(negedge clock);
        a_we = 1'b1; a_wa = 5'd5; a_wd = 32'hDEADBEEF;
        a_iv = 1'b1; a_ir = 5'd6;
        a_ra = {5'd6, 5'd5};
        @(negedge clock);
        a_we = 1'b0; a_iv = 1'b0;
        #1;
        checks++;
        if (a_rd[31:0] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL reset_pre_rd: got %h want %h", a_rd[31:0], 32'hDEADBEEF);
        end
        checks++;
        if (a_pc !== 6'd1) begin
            errors++; $display("FAIL reset_pre_pc: got %0d want 1", a_pc);
        end
        checks++;
        if (a_busy[1] !== 1'b1) begin
            errors++; $display("FAIL reset_pre_busy: got %b want 1", a_busy[1]);
        end
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (a_rd[31:0] !== 32'h0) begin
            errors++; $display("FAIL reset_rd: got %h want 0", a_rd[31:0]);
        end
        checks++;
        if (a_pc !== 6'd0) begin
            errors++; $display("FAIL reset_pc: got %0d want 0", a_pc);
        end
        checks++;
        if (a_busy !== 2'b00) begin
            errors++; $display("FAIL reset_busy: got %b want 00", a_busy);
        end
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        checks++;
        if (a_rd !== 64'h0) begin
            errors++; $display("FAIL reset_after_rd: got %h want 0", a_rd);
        end
    endtask

    task automatic test_bypass;
        @(negedge clock);
        a_we = 1'b1; a_wa = 5'd7; a_wd = 32'h12345678;
        a_ra = {5'd7, 5'd7};
        #1;
        checks++;
        if (a_rd[31:0] !== 32'h12345678) begin
            errors++; $display("FAIL bypass_p0: got %h want %h", a_rd[31:0], 32'h12345678);
        end
        checks++;
        if (a_rd[63:32] !== 32'h12345678) begin
            errors++; $display("FAIL bypass_p1: got %h want %h", a_rd[63:32], 32'h12345678);
        end
        @(negedge clock);
        a_we = 1'b0;
        #1;
        checks++;
        if (a_rd[31:0] !== 32'h12345678) begin
            errors++; $display("FAIL stored_p0: got %h want %h", a_rd[31:0], 32'h12345678);
        end
        checks++;
        if (a_rd[63:32] !== 32'h12345678) begin
            errors++; $display("FAIL stored_p1: got %h want %h", a_rd[63:32], 32'h12345678);
        end
    endtask

    task automatic test_zero_reg;
        // Instance A: r0 hardwired
        @(negedge clock);
        a_we = 1'b1; a_wa = 5'd0; a_wd = 32'hFFFFFFFF;
        a_iv = 1'b1; a_ir = 5'd0;
        a_ra = {5'd7, 5'd0};
        #1;
        checks++;
        if (a_rd[31:0] !== 32'h0) begin
            errors++; $display("FAIL zero_bypass_rd: got %h want 0", a_rd[31:0]);
        end
        @(negedge clock);
        a_we = 1'b0; a_iv = 1'b0;
        #1;
        checks++;
        if (a_rd[31:0] !== 32'h0) begin
            errors++; $display("FAIL zero_rd: got %h want 0", a_rd[31:0]);
        end
        checks++;
        if (a_pc !== 6'd0) begin
            errors++; $display("FAIL zero_pc: got %0d want 0", a_pc);
        end
        checks++;
        if (a_busy[0] !== 1'b0) begin
            errors++; $display("FAIL zero_busy: got %b want 0", a_busy[0]);
        end
        // Instance B: r0 is an ordinary register
        @(negedge clock);
        b_we = 1'b1; b_wa = 5'd0; b_wd = 32'hFFFFFFFF;
        b_iv = 1'b1; b_ir = 5'd0;
        b_ra = {5'd0, 5'd0};
        #1;
        checks++;
        if (b_rd[31:0] !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL nz_bypass_rd: got %h want ffffffff", b_rd[31:0]);
        end
        @(negedge clock);
        b_we = 1'b0; b_iv = 1'b0;
        #1;
        checks++;
        if (b_rd[63:32] !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL nz_rd: got %h want ffffffff", b_rd[63:32]);
        end
        checks++;
        if (b_pc !== 6'd1) begin
            errors++; $display("FAIL nz_pc: got %0d want 1", b_pc);
        end
        checks++;
        if (b_busy !== 2'b11) begin
            errors++; $display("FAIL nz_busy: got %b want 11", b_busy);
        end
    endtask

    task automatic test_scoreboard;
        @(negedge clock);
        a_iv = 1'b1; a_ir = 5'd3;
        @(negedge clock);
        a_ir = 5'd4;
        @(negedge clock);
        a_iv = 1'b0;
        a_ra = {5'd4, 5'd3};
        #1;
        checks++;
        if (a_pc !== 6'd2) begin
            errors++; $display("FAIL sb_pc2: got %0d want 2", a_pc);
        end
        checks++;
        if (a_busy !== 2'b11) begin
            errors++; $display("FAIL sb_busy_both: got %b want 11", a_busy);
        end
        @(negedge clock);
        a_we = 1'b1; a_wa = 5'd3; a_wd = 32'h0000000A;
        #1;
        checks++;
        if (a_busy !== 2'b10) begin
            errors++; $display("FAIL sb_busy_wb: got %b want 10", a_busy);
        end
        checks++;
        if (a_rd[31:0] !== 32'h0000000A) begin
            errors++; $display("FAIL sb_rd_wb: got %h want a", a_rd[31:0]);
        end
        checks++;
        if (a_pc !== 6'd2) begin
            errors++; $display("FAIL sb_pc_before_edge: got %0d want 2", a_pc);
        end
        @(negedge clock);
        a_we = 1'b0;
        #1;
        checks++;
        if (a_pc !== 6'd1) begin
            errors++; $display("FAIL sb_pc1: got %0d want 1", a_pc);
        end
        checks++;
        if (a_busy !== 2'b10) begin
            errors++; $display("FAIL sb_busy_after: got %b want 10", a_busy);
        end
    endtask

    task automatic test_simultaneous;
        // r4 still pending from the previous scenario.
        @(negedge clock);
        a_iv = 1'b1; a_ir = 5'd9;
        @(negedge clock);
        a_iv = 1'b0;
        a_ra = {5'd9, 5'd9};
        #1;
        checks++;
        if (a_pc !== 6'd2) begin
            errors++; $display("FAIL sim_pc_pre: got %0d want 2", a_pc);
        end
        @(negedge clock);
        a_we = 1'b1; a_wa = 5'd9; a_wd = 32'h00000055;
        a_iv = 1'b1; a_ir = 5'd9;
        #1;
        checks++;
        if (a_rd[31:0] !== 32'h00000055 || a_busy !== 2'b00) begin
            errors++; $display("FAIL sim_same_cycle: got rd=%h busy=%b want rd=55 busy=00", a_rd[31:0], a_busy);
        end
        @(negedge clock);
        a_we = 1'b0; a_iv = 1'b0;
        #1;
        checks++;
        if (a_rd[63:32] !== 32'h00000055) begin
            errors++; $display("FAIL sim_rd: got %h want 55", a_rd[63:32]);
        end
        checks++;
        if (a_pc !== 6'd2) begin
            errors++; $display("FAIL sim_pc: got %0d want 2", a_pc);
        end
        checks++;
        if (a_busy !== 2'b11) begin
            errors++; $display("FAIL sim_busy: got %b want 11", a_busy);
        end
    endtask

    task automatic test_multiport;
        logic [15:0] exp_rd [4];
        exp_rd[0] = 16'h1111; exp_rd[1] = 16'h3333;
        exp_rd[2] = 16'h5555; exp_rd[3] = 16'h7777;
        for (int n = 1; n < 8; n++) begin
            @(negedge clock);
            c_we = 1'b1; c_wa = 3'(n); c_wd = 16'(16'h1111 * n);
        end
        @(negedge clock);
        c_we = 1'b0;
        c_ra = {3'd7, 3'd5, 3'd3, 3'd1};
        #1;
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (c_rd[p*16 +: 16] !== exp_rd[p]) begin
                errors++; $display("FAIL mp_rd%0d: got %h want %h", p, c_rd[p*16 +: 16], exp_rd[p]);
            end
        end
        for (int n = 0; n < 8; n++) begin
            @(negedge clock);
            c_iv = 1'b1; c_ir = 3'(n);
        end
        @(negedge clock);
        c_ir = 3'd7;
        @(negedge clock);
        c_iv = 1'b0;
        #1;
        checks++;
        if (c_pc !== 4'd7) begin
            errors++; $display("FAIL mp_pc: got %0d want 7", c_pc);
        end
        checks++;
        if (c_busy !== 4'b1111) begin
            errors++; $display("FAIL mp_busy: got %b want 1111", c_busy);
        end
        c_ra = {3'd0, 3'd0, 3'd0, 3'd2};
        #1;
        checks++;
        if (c_busy !== 4'b0001 || c_rd !== {16'h0, 16'h0, 16'h0, 16'h2222}) begin
            errors++; $display("FAIL mp_zero_ports: got busy=%b rd=%h want busy=0001 rd=0000000000002222", c_busy, c_rd);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        a_we = 1'b0; a_wa = '0; a_wd = '0; a_iv = 1'b0; a_ir = '0; a_ra = '0;
        b_we = 1'b0; b_wa = '0; b_wd = '0; b_iv = 1'b0; b_ir = '0; b_ra = '0;
        c_we = 1'b0; c_wa = '0; c_wd = '0; c_iv = 1'b0; c_ir = '0; c_ra = '0;
        #1;
        checks++;
        if (a_pc !== 6'd0 || b_pc !== 6'd0 || c_pc !== 4'd0) begin
            errors++; $display("FAIL init_pc: got %0d/%0d/%0d want 0/0/0", a_pc, b_pc, c_pc);
        end
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        test_reset();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_simultaneous();
        test_multiport();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
